rocketcpu_audio_regbank: RTL and testbench
==========================================

// Module: rocketcpu_audio_regbank
// PURPOSE
//  Parametrised Wishbone-slave register bank that hands control parameters from the RISC-V core to the audio datapath.
//  CPU writes land in shadow registers; live outputs update atomically on an audio sample strobe, so the DSP never sees a half-written parameter set.
//  Byte-lane writes, sampled readback of N_INPUTS datapath values, and a strobe counter are included.
//  Sits on the CPU Wishbone bus next to the other rocketcpu peripherals.
// PARAMETERS
//  BASE_ADDR    32'h1000_0000  byte address of shadow param 0
//  N_PARAMS     16             number of 32-bit output parameters (1..64)
//  N_INPUTS     4              number of 32-bit readable datapath inputs (1..16)
//  INPUT_OFFS   32'h0001_0000  offset from BASE_ADDR of input window
// PORTS
//  i_wb_clk        in   1            system clock
//  i_wb_rst        in   1            asynchronous, active-high reset
//  i_wb_adr        in   32           byte address
//  i_wb_dat        in   32           write data
//  i_wb_sel        in   4            byte lane enables
//  i_wb_we         in   1            write enable
//  i_wb_cyc        in   1            cycle valid
//  o_wb_rdt        out  32           read data, valid while o_wb_ack
//  o_wb_ack        out  1            one-cycle acknowledge
//  i_sample_strobe in   1            one-cycle pulse per audio sample
//  i_iparam        in   N_INPUTS*32  datapath values, input j in bits [32j+31:32j]
//  o_param         out  N_PARAMS*32  live parameters, param i in bits [32i+31:32i]
//  o_commit        out  1            one-cycle pulse when live set updated
// BEHAVIOUR
//  Reset: shadow, live, snapshots, CTRL, SAMPLE_CNT, o_wb_rdt, o_wb_ack, o_commit = 0.
//  Map (offset from BASE_ADDR):
//   0x000+4i    SHADOW[i] R/W
//   0x100       CTRL: bit0 AUTO (R/W); bit1 COMMIT (W1 sets pending, reads pending)
//   0x104       STATUS RO: bit0 pending, bit1 dirty
//   0x108       SAMPLE_CNT RO: strobes since reset, wraps 2^32-1 -> 0
//   INPUT_OFFS+4j  SNAP[j] RO
//  Unmapped or RO-write: write ignored, read returns 0, still acked.
//  Bus FSM IDLE/ACK:
//   IDLE & i_wb_cyc: write performed and o_wb_rdt loaded at this edge; -> ACK.
//   ACK: o_wb_ack=1 for exactly one cycle; -> IDLE.
//   Back-to-back cycles are acked every second cycle; a write executes once per ack.
//  Byte writes: each lane k with i_wb_sel[k]=1 updates byte k; sel=0 acks without change.
//  Any shadow write sets dirty.
//  Commit (on i_sample_strobe, with pending | (AUTO & dirty)):
//   live <= shadow; pending, dirty <= 0; o_commit pulses the next cycle.
//  Every strobe: SNAP[j] <= i_iparam[j]; SAMPLE_CNT += 1.
//  Simultaneous strobe and shadow write: live takes the pre-write shadow; dirty stays 1.
//  Simultaneous strobe and COMMIT write: pending stays set; commit happens on the next strobe.
//  Reset mid-transaction: ack drops immediately and the write is lost.
// STRUCTURE
//  Include rocketcpu_audio_map.vh: CTRL/STATUS/CNT offsets, CTRL bit indices.
//  Single module; byte-merge is a local function. No sub-module.
// TESTING
//  1. Reset, read 0x1000_0000/0x1000_0104 -> 0; o_param all 0; ack exactly 1 cycle after cyc.
//  2. Write 0xDEADBEEF sel=4'b0101 to param 3 -> read 0x00AD00EF; o_param unchanged until commit.
//  3. Write CTRL=2, pulse strobe -> o_commit 1 cycle later; o_param[3]=0x00AD00EF; STATUS=0.
//  4. AUTO=1, write param 0=5 on the same cycle as strobe -> live 0 unchanged; next strobe -> 5.
//  5. i_iparam[1]=0x1234 then strobe -> read BASE+0x1_0004 = 0x1234; SAMPLE_CNT=count of strobes.
//  6. Read 0x1000_0200 -> ack, data 0; assert reset during ACK -> o_wb_ack 0 asynchronously.

Source files
------------

// File: rtl/rocketcpu_audio_regbank_pkg.sv
// Shared definitions for the audio parameter register bank: register offsets,
// control/status bit positions, bus state encoding and the byte-lane merge.
package rocketcpu_audio_regbank_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [31:0] CTRL_OFFS   = 32'h0000_0100;
  localparam logic [31:0] STATUS_OFFS = 32'h0000_0104;
  localparam logic [31:0] CNT_OFFS    = 32'h0000_0108;

  // CTRL bit positions
  localparam int CTRL_AUTO   = 0;
  localparam int CTRL_COMMIT = 1;

  // STATUS bit positions
  localparam int STAT_PENDING = 0;
  localparam int STAT_DIRTY   = 1;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // Replace each byte of old_w whose lane is enabled with the byte of new_w
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int k = 0; k < 4; k++) begin
      if (sel[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rocketcpu_audio_regbank_if.sv
// Wishbone classic slave bus as seen by the audio register bank.
interface rocketcpu_audio_regbank_if;
  logic [31:0] adr;
  logic [31:0] dat;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (output adr, dat, sel, we, cyc, input rdt, ack);
  modport slave  (input adr, dat, sel, we, cyc, output rdt, ack);
endinterface

// File: rtl/rocketcpu_audio_regbank.sv
// Wishbone register bank carrying CPU-written control parameters to the audio
// datapath. Writes land in shadow registers; the live set copied to o_param
// only changes on a sample strobe so the DSP always sees a consistent set.
module rocketcpu_audio_regbank
  import rocketcpu_audio_regbank_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          N_PARAMS   = 16,
  parameter int          N_INPUTS   = 4,
  parameter logic [31:0] INPUT_OFFS = 32'h0001_0000
) (
  input  logic                     i_wb_clk,
  input  logic                     i_wb_rst,
  rocketcpu_audio_regbank_if.slave wb,
  input  logic                     i_sample_strobe,
  input  logic [N_INPUTS*32-1:0]   i_iparam,
  output logic [N_PARAMS*32-1:0]   o_param,
  output logic                     o_commit
);

  logic [31:0]          shadow [N_PARAMS];
  logic [31:0]          live   [N_PARAMS];
  logic [31:0]          snap   [N_INPUTS];
  logic                 auto_en;
  logic                 pending;
  logic                 dirty;
  logic [31:0]          sample_cnt;
  bus_state_e           state;

  logic [31:0]          off;
  logic [N_PARAMS-1:0]  hit_shadow;
  logic [N_INPUTS-1:0]  hit_snap;
  logic                 hit_ctrl;
  logic                 hit_status;
  logic                 hit_cnt;
  logic [31:0]          rd_data;
  logic                 accept;
  logic                 wr_en;
  logic                 do_commit;

  // Address decode and readback mux; unmapped or misaligned addresses read 0
  always_comb begin
    off        = wb.adr - BASE_ADDR;
    hit_ctrl   = (off == CTRL_OFFS);
    hit_status = (off == STATUS_OFFS);
    hit_cnt    = (off == CNT_OFFS);
    rd_data    = '0;
    for (int i = 0; i < N_PARAMS; i++) begin
      hit_shadow[i] = (off == 32'(i * 4));
      if (hit_shadow[i]) rd_data = shadow[i];
    end
    for (int j = 0; j < N_INPUTS; j++) begin
      hit_snap[j] = (off == INPUT_OFFS + 32'(j * 4));
      if (hit_snap[j]) rd_data = snap[j];
    end
    if (hit_ctrl) begin
      rd_data[CTRL_AUTO]   = auto_en;
      rd_data[CTRL_COMMIT] = pending;
    end
    if (hit_status) begin
      rd_data[STAT_PENDING] = pending;
      rd_data[STAT_DIRTY]   = dirty;
    end
    if (hit_cnt) rd_data = sample_cnt;
  end

  // A cycle is taken only from IDLE, so a held cyc is served every other clock
  assign accept    = (state == BUS_IDLE) && wb.cyc;
  assign wr_en     = accept && wb.we;
  assign do_commit = i_sample_strobe && (pending || (auto_en && dirty));

  // Bus FSM: capture read data on accept, then ack for exactly one cycle
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      state  <= BUS_IDLE;
      wb.ack <= 1'b0;
      wb.rdt <= '0;
    end else begin
      case (state)
        BUS_IDLE: begin
          wb.ack <= 1'b0;
          if (wb.cyc) begin
            state  <= BUS_ACK;
            wb.ack <= 1'b1;
            wb.rdt <= rd_data;
          end
        end
        BUS_ACK: begin
          state  <= BUS_IDLE;
          wb.ack <= 1'b0;
        end
        default: begin
          state  <= BUS_IDLE;
          wb.ack <= 1'b0;
        end
      endcase
    end
  end

  // Shadow registers: byte-lane writes from the CPU
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      for (int i = 0; i < N_PARAMS; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < N_PARAMS; i++) begin
        if (wr_en && hit_shadow[i]) shadow[i] <= byte_merge(shadow[i], wb.dat, wb.sel);
      end
    end
  end

  // Commit logic: a same-edge CPU write wins over the commit's clear of
  // dirty/pending, while live still takes the pre-write shadow contents
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      for (int i = 0; i < N_PARAMS; i++) live[i] <= '0;
      auto_en  <= 1'b0;
      pending  <= 1'b0;
      dirty    <= 1'b0;
      o_commit <= 1'b0;
    end else begin
      o_commit <= do_commit;
      if (do_commit) begin
        for (int i = 0; i < N_PARAMS; i++) live[i] <= shadow[i];
        pending <= 1'b0;
        dirty   <= 1'b0;
      end
      if (wr_en && (|hit_shadow)) dirty <= 1'b1;
      if (wr_en && hit_ctrl && wb.sel[0]) begin
        auto_en <= wb.dat[CTRL_AUTO];
        if (wb.dat[CTRL_COMMIT]) pending <= 1'b1;
      end
    end
  end

  // Per-strobe sampling of datapath values and strobe counting
  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      for (int j = 0; j < N_INPUTS; j++) snap[j] <= '0;
      sample_cnt <= '0;
    end else if (i_sample_strobe) begin
      for (int j = 0; j < N_INPUTS; j++) snap[j] <= i_iparam[32*j +: 32];
      sample_cnt <= sample_cnt + 32'd1;
    end
  end

  for (genvar i = 0; i < N_PARAMS; i++) begin : g_param
    assign o_param[32*i +: 32] = live[i];
  end

endmodule

// File: tb/tb_rocketcpu_audio_regbank.sv
// Directed bench for the audio register bank with a transaction-level model
// checked every cycle, plus literal expectations at key points.
module tb_rocketcpu_audio_regbank;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] CTRL   = BASE + 32'h100;
  localparam logic [31:0] STATUS = BASE + 32'h104;
  localparam logic [31:0] CNT    = BASE + 32'h108;
  localparam logic [31:0] INP    = BASE + 32'h1_0000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         strobe = 1'b0;
  logic [127:0] iparam = '0;
  logic [511:0] o_param;
  logic         o_commit;

  rocketcpu_audio_regbank_if bus ();

  rocketcpu_audio_regbank dut (
    .i_wb_clk        (clk),
    .i_wb_rst        (rst),
    .wb              (bus),
    .i_sample_strobe (strobe),
    .i_iparam        (iparam),
    .o_param         (o_param),
    .o_commit        (o_commit)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Model state
  logic [31:0] m_shadow [16];
  logic [31:0] m_live   [16];
  logic [31:0] m_snap   [4];
  logic [31:0] m_cnt, m_rdt;
  bit          m_auto, m_pending, m_dirty, m_ack, m_commit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m_shadow[i] = '0; m_live[i] = '0; end
    for (int j = 0; j < 4; j++) m_snap[j] = '0;
    m_cnt = '0; m_rdt = '0;
    m_auto = 0; m_pending = 0; m_dirty = 0; m_ack = 0; m_commit = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    if (off[1:0] != 2'b00) return '0;
    if (off < 32'd64) return m_shadow[off/4];
    if (off == 32'h100) return {30'd0, m_pending, m_auto};
    if (off == 32'h104) return {30'd0, m_dirty, m_pending};
    if (off == 32'h108) return m_cnt;
    if (off >= 32'h1_0000 && off < 32'h1_0010) return m_snap[(off - 32'h1_0000) / 4];
    return '0;
  endfunction

  // One clock: drive inputs, take the edge, advance the model, settle 1ns
  task automatic step(input logic stb, input logic c, input logic w,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd, off;
    bit acc, comm;
    strobe = stb; bus.cyc = c; bus.we = w; bus.adr = a; bus.dat = d; bus.sel = s;
    @(posedge clk);
    acc  = c && !m_ack;
    rd   = m_read(a);
    comm = stb && (m_pending || (m_auto && m_dirty));
    if (stb) begin
      for (int j = 0; j < 4; j++) m_snap[j] = iparam[32*j +: 32];
      m_cnt = m_cnt + 1;
    end
    if (comm) begin
      for (int i = 0; i < 16; i++) m_live[i] = m_shadow[i];
      m_pending = 0; m_dirty = 0;
    end
    if (acc && w) begin
      off = a - BASE;
      if (off < 32'd64 && off[1:0] == 2'b00) begin
        for (int k = 0; k < 4; k++)
          if (s[k]) m_shadow[off/4][8*k +: 8] = d[8*k +: 8];
        m_dirty = 1;
      end else if (off == 32'h100 && s[0]) begin
        m_auto = d[0];
        if (d[1]) m_pending = 1;
      end
    end
    m_commit = comm;
    m_ack    = acc;
    if (acc) m_rdt = rd;
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, '0, '0, '0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    step(0, 1, 1, a, d, s);
    idle();
  endtask

  task automatic lit_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    step(0, 1, 0, a, '0, '0);
    chk({name, "_ack"}, {31'd0, bus.ack}, 32'd1);
    chk(name, bus.rdt, exp);
    idle();
    chk({name, "_ackdrop"}, {31'd0, bus.ack}, 32'd0);
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", {31'd0, bus.ack}, {31'd0, m_ack});
      if (m_ack) chk("rdt", bus.rdt, m_rdt);
      chk("commit", {31'd0, o_commit}, {31'd0, m_commit});
      for (int i = 0; i < 16; i++)
        chk($sformatf("param%0d", i), o_param[32*i +: 32], m_live[i]);
    end
  end

  initial begin
    bus.cyc = 0; bus.we = 0; bus.adr = '0; bus.dat = '0; bus.sel = '0;
    model_reset();
    #2;
    chk("rst_ack", {31'd0, bus.ack}, 32'd0);
    chk("rst_commit", {31'd0, o_commit}, 32'd0);
    chk("rst_rdt", bus.rdt, 32'd0);
    for (int i = 0; i < 16; i++) chk("rst_param", o_param[32*i +: 32], 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    chk_en = 1;

    // Reset-state readback and ack timing
    lit_read("rd_p0", BASE, 32'd0);
    lit_read("rd_status0", STATUS, 32'd0);

    // Byte-lane write lands in shadow only
    wr(BASE + 12, 32'hDEAD_BEEF, 4'b0101);
    lit_read("rd_p3", BASE + 12, 32'h00AD_00EF);
    chk("p3_live_unchanged", o_param[96 +: 32], 32'd0);
    lit_read("status_dirty", STATUS, 32'h2);

    // Explicit commit
    wr(CTRL, 32'h2, 4'hF);
    lit_read("ctrl_pending", CTRL, 32'h2);
    step(1, 0, 0, '0, '0, '0);                      // strobe 1
    chk("commit_pulse", {31'd0, o_commit}, 32'd1);
    chk("p3_live", o_param[96 +: 32], 32'h00AD_00EF);
    idle();
    chk("commit_one_cycle", {31'd0, o_commit}, 32'd0);
    lit_read("status_clear", STATUS, 32'd0);

    // AUTO commit with a write colliding with the strobe
    wr(CTRL, 32'h1, 4'hF);
    wr(BASE, 32'd7, 4'hF);
    step(1, 1, 1, BASE, 32'd5, 4'hF);               // strobe 2
    chk("p0_prewrite", o_param[0 +: 32], 32'd7);
    idle();
    lit_read("status_dirty2", STATUS, 32'h2);
    step(1, 0, 0, '0, '0, '0);                      // strobe 3
    chk("p0_next", o_param[0 +: 32], 32'd5);
    idle();

    // Snapshot and strobe counter
    iparam[63:32] = 32'h0000_1234;
    step(1, 0, 0, '0, '0, '0);                      // strobe 4
    idle();
    lit_read("snap1", INP + 4, 32'h0000_1234);
    lit_read("cnt4", CNT, 32'd4);

    // COMMIT write colliding with a strobe keeps pending set
    wr(CTRL, 32'h2, 4'hF);
    wr(BASE + 20, 32'h0000_CAFE, 4'hF);
    step(1, 1, 1, CTRL, 32'h2, 4'hF);               // strobe 5
    chk("p5_live", o_param[160 +: 32], 32'h0000_CAFE);
    chk("commit5", {31'd0, o_commit}, 32'd1);
    idle();
    lit_read("status_pending", STATUS, 32'h1);
    step(1, 0, 0, '0, '0, '0);                      // strobe 6
    chk("commit6", {31'd0, o_commit}, 32'd1);
    idle();
    lit_read("cnt6", CNT, 32'd6);

    // Unmapped, read-only and sel=0 writes
    lit_read("unmapped", BASE + 32'h200, 32'd0);
    wr(STATUS, 32'hFFFF_FFFF, 4'hF);
    lit_read("status_ro", STATUS, 32'd0);
    wr(BASE + 20, 32'd0, 4'b0000);
    lit_read("sel0", BASE + 20, 32'h0000_CAFE);
    wr(INP, 32'd1, 4'hF);
    lit_read("snap_ro", INP, 32'd0);

    // Back-to-back cycles: acked every second clock
    for (int n = 0; n < 4; n++) step(0, 1, 1, BASE + 8, 32'h11, 4'hF);
    idle();
    for (int n = 0; n < 4; n++) step(0, 1, 0, BASE + 8, '0, '0);
    idle();
    lit_read("p2", BASE + 8, 32'h11);

    // Reset during ACK
    step(0, 1, 0, BASE + 20, '0, '0);
    chk("mid_ack", {31'd0, bus.ack}, 32'd1);
    chk("mid_rdt", bus.rdt, 32'h0000_CAFE);
    bus.cyc = 0;
    rst = 1;
    model_reset();
    #1;
    chk("rst_async_ack", {31'd0, bus.ack}, 32'd0);
    chk("rst_async_rdt", bus.rdt, 32'd0);
    chk("rst_async_p5", o_param[160 +: 32], 32'd0);
    @(posedge clk); #1;
    rst = 0;
    lit_read("p5_after_rst", BASE + 20, 32'd0);
    lit_read("cnt_after_rst", CNT, 32'd0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
